four_wires: RTL and testbench
=============================

Name: four_wires

Overview:
- Signal-routing block that maps three input buses onto four output buses: a to w, b to both x and y, c to z.
- Routing is carried through a configurable register pipeline, so the block can sit between timing domains of a datapath as a fan-out/retiming stage.
- A valid flag travels alongside the data.
- With STAGES=0 the block is pure combinational wiring.

Parameters:
- WIDTH, 1, bit width of every data input and output bus.
- STAGES, 1, number of register stages between inputs and outputs. Legal range 0..4. 0 means combinational passthrough.

Ports:
- clk  input  1  rising-edge clock for all pipeline registers.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b, c in the current cycle.
- a  input  WIDTH  source for w.
- b  input  WIDTH  source for x and y.
- c  input  WIDTH  source for z.
- out_valid  output  1  in_valid delayed by STAGES cycles.
- w  output  WIDTH  equals a, delayed by STAGES.
- x  output  WIDTH  equals b, delayed by STAGES.
- y  output  WIDTH  equals b, delayed by STAGES. Always bit-identical to x.
- z  output  WIDTH  equals c, delayed by STAGES.

Behaviour:
- Mapping, fixed at all times: w←a, x←b, y←b, z←c. There is no swapping, inversion or combination of inputs.
- STAGES=0:
  - Outputs follow inputs combinationally; out_valid=in_valid.
  - clk and rst have no effect.
  - No registers are inferred.
- STAGES=N, 1..4:
  - Each stage registers the a, b, c data and in_valid on the rising edge of clk.
  - Outputs are driven from the last stage, giving a latency of exactly N cycles.
  - Input a sampled at edge k appears on w after edge k+N-1, i.e. stable for the cycle after edge k+N-1.
  - x and y are both driven from the single registered copy of b, so they can never diverge.
- Data registers load every cycle regardless of in_valid. in_valid only propagates as a tag; it does not gate loading.
- Reset:
  - When rst=1, all stage registers clear to 0 immediately, without waiting for a clock edge.
  - w, x, y, z and out_valid therefore read 0 while rst is high.
  - Reset asserted mid-stream discards all in-flight data.
  - After rst deasserts, the first new data reaches the outputs N cycles later. Until then the outputs hold 0 with out_valid=0.
- Reset-to-clock interaction:
  - An edge of clk coincident with rst=1 loads nothing.
  - Release of rst is assumed synchronous to clk by the integrating design; the block performs no internal reset synchronisation.
- Elaboration: STAGES outside 0..4 or WIDTH<1 is an elaboration error, raised via a generate-time check.
- There is no backpressure. Throughput is one transfer per cycle.

Test Plan:
- Exhaustive truth table: WIDTH=1, STAGES=0, sweep a,b,c over all 8 combinations, holding each 10 time units. Required for every combination: w=a, x=b, y=b, z=c. Example: a=1,b=0,c=1 → w=1,x=0,y=0,z=1.
- Latency: WIDTH=8, STAGES=2. Drive a=0x11, b=0x22, c=0x33 with in_valid=1 for one cycle, then zeros with in_valid=0. Required: exactly 2 edges later w=0x11, x=0x22, y=0x22, z=0x33 and out_valid=1 for one cycle; 0 on the cycles before and after.
- Streaming: STAGES=1. Drive a random sequence on a,b,c every cycle. Required: each output equals its mapped input from the previous cycle, on every cycle, and x==y on every cycle.
- Async reset mid-stream: STAGES=3 with a full pipe (out_valid=1). Assert rst between clock edges. Required: all outputs read 0 before the next edge. After release, outputs stay 0 for 3 cycles, then new data appears.
- Reset with clock edge: hold rst=1 across several edges with nonzero inputs. Required: outputs remain 0 and out_valid remains 0 throughout.
- Width corner: WIDTH=16, STAGES=4. Drive a=0xFFFF, b=0x8001, c=0x0000. Required: after 4 cycles w=0xFFFF, x=y=0x8001, z=0x0000, with no bit truncation.

Source files
------------

// File: rtl/four_wires_if.sv
// Bundle of the routed data buses and valid tag for four_wires.
// The master side drives in_valid/a/b/c; the slave (the router) drives the outputs.
interface four_wires_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;

    modport master (
        output in_valid, a, b, c,
        input  out_valid, w, x, y, z
    );

    modport slave (
        input  in_valid, a, b, c,
        output out_valid, w, x, y, z
    );
endinterface

// File: rtl/four_wires.sv
// Fan-out/retiming stage: routes a->w, b->x and y, c->z through STAGES register
// stages (0 = plain wiring), with a valid tag travelling alongside the data.
module four_wires #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    four_wires_if.slave bus
);

    generate
        if (STAGES < 0 || STAGES > 4 || WIDTH < 1) begin : g_param_check
            $error("four_wires: STAGES must be 0..4 and WIDTH >= 1");
        end
    endgenerate

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } stage_t;

    generate
        if (STAGES == 0) begin : g_comb
            assign bus.out_valid = bus.in_valid;
            assign bus.w         = bus.a;
            assign bus.x         = bus.b;
            assign bus.y         = bus.b;
            assign bus.z         = bus.c;
        end else begin : g_pipe
            stage_t stage_d [STAGES];
            stage_t stage_q [STAGES];

            always_comb begin
                stage_d[0].valid = bus.in_valid;
                stage_d[0].a     = bus.a;
                stage_d[0].b     = bus.b;
                stage_d[0].c     = bus.c;
                for (int i = 1; i < STAGES; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Data loads every cycle; valid is only a tag and never gates loading.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            // x and y share one registered copy of b so they cannot diverge.
            assign bus.out_valid = stage_q[STAGES-1].valid;
            assign bus.w         = stage_q[STAGES-1].a;
            assign bus.x         = stage_q[STAGES-1].b;
            assign bus.y         = stage_q[STAGES-1].b;
            assign bus.z         = stage_q[STAGES-1].c;
        end
    endgenerate

endmodule

// File: tb/tb_four_wires.sv
// Directed self-checking bench for four_wires across STAGES 0..4 and several widths.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_four_wires;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    four_wires_if #(.WIDTH(1))  bus0 ();
    four_wires_if #(.WIDTH(8))  bus1 ();
    four_wires_if #(.WIDTH(8))  bus2 ();
    four_wires_if #(.WIDTH(8))  bus3 ();
    four_wires_if #(.WIDTH(16)) bus4 ();

    four_wires #(.WIDTH(1),  .STAGES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    four_wires #(.WIDTH(8),  .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    four_wires #(.WIDTH(8),  .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    four_wires #(.WIDTH(8),  .STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    four_wires #(.WIDTH(16), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] abc, input logic vld);
        bus0.a        = abc[2];
        bus0.b        = abc[1];
        bus0.c        = abc[0];
        bus0.in_valid = vld;
        #10;
    endtask

    task automatic checkAll3(input string tag, input logic [7:0] ew, input logic [7:0] ex,
                             input logic [7:0] ez, input logic ev);
        checkOutput({tag, ".w"}, 32'(bus3.w), 32'(ew));
        checkOutput({tag, ".x"}, 32'(bus3.x), 32'(ex));
        checkOutput({tag, ".y"}, 32'(bus3.y), 32'(ex));
        checkOutput({tag, ".z"}, 32'(bus3.z), 32'(ez));
        checkOutput({tag, ".v"}, 32'(bus3.out_valid), 32'(ev));
    endtask

    logic [7:0] prevA, prevB, prevC;
    logic       prevV;
    logic [7:0] na, nb, nc;

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.in_valid = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.in_valid = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.c = '0; bus2.in_valid = 1'b0;
        bus3.a = '0; bus3.b = '0; bus3.c = '0; bus3.in_valid = 1'b0;
        bus4.a = '0; bus4.b = '0; bus4.c = '0; bus4.in_valid = 1'b0;

        #2;
        checkOutput("reset.w2", 32'(bus2.w), 32'h0);
        checkOutput("reset.v4", 32'(bus4.out_valid), 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Combinational truth table, STAGES=0.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            applyStimulus(abc, abc[0] ^ abc[2]);
            checkOutput("comb.w", 32'(bus0.w), 32'(abc[2]));
            checkOutput("comb.x", 32'(bus0.x), 32'(abc[1]));
            checkOutput("comb.y", 32'(bus0.y), 32'(abc[1]));
            checkOutput("comb.z", 32'(bus0.z), 32'(abc[0]));
            checkOutput("comb.v", 32'(bus0.out_valid), 32'(abc[0] ^ abc[2]));
        end

        // Latency of 2 on a single tagged transfer.
        nextCycle();
        bus2.a = 8'h11; bus2.b = 8'h22; bus2.c = 8'h33; bus2.in_valid = 1'b1;
        nextCycle();
        checkOutput("lat.e1.w", 32'(bus2.w), 32'h0);
        checkOutput("lat.e1.v", 32'(bus2.out_valid), 32'h0);
        bus2.a = '0; bus2.b = '0; bus2.c = '0; bus2.in_valid = 1'b0;
        nextCycle();
        checkOutput("lat.e2.w", 32'(bus2.w), 32'h11);
        checkOutput("lat.e2.x", 32'(bus2.x), 32'h22);
        checkOutput("lat.e2.y", 32'(bus2.y), 32'h22);
        checkOutput("lat.e2.z", 32'(bus2.z), 32'h33);
        checkOutput("lat.e2.v", 32'(bus2.out_valid), 32'h1);
        nextCycle();
        checkOutput("lat.e3.w", 32'(bus2.w), 32'h0);
        checkOutput("lat.e3.v", 32'(bus2.out_valid), 32'h0);

        // Random streaming through STAGES=1.
        prevA = '0; prevB = '0; prevC = '0; prevV = 1'b0;
        for (int n = 0; n < 20; n++) begin
            bus1.a = 8'($urandom_range(255, 0));
            bus1.b = 8'($urandom_range(255, 0));
            bus1.c = 8'($urandom_range(255, 0));
            bus1.in_valid = 1'($urandom_range(1, 0));
            prevA = bus1.a; prevB = bus1.b; prevC = bus1.c; prevV = bus1.in_valid;
            nextCycle();
            checkOutput("stream.w", 32'(bus1.w), 32'(prevA));
            checkOutput("stream.x", 32'(bus1.x), 32'(prevB));
            checkOutput("stream.y", 32'(bus1.y), 32'(bus1.x));
            checkOutput("stream.z", 32'(bus1.z), 32'(prevC));
            checkOutput("stream.v", 32'(bus1.out_valid), 32'(prevV));
        end

        // Width corner, STAGES=4.
        bus4.a = 16'hFFFF; bus4.b = 16'h8001; bus4.c = 16'h0000; bus4.in_valid = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            nextCycle();
            checkOutput("wide.early.w", 32'(bus4.w), 32'h0);
            checkOutput("wide.early.v", 32'(bus4.out_valid), 32'h0);
        end
        nextCycle();
        checkOutput("wide.w", 32'(bus4.w), 32'hFFFF);
        checkOutput("wide.x", 32'(bus4.x), 32'h8001);
        checkOutput("wide.y", 32'(bus4.y), 32'h8001);
        checkOutput("wide.z", 32'(bus4.z), 32'h0000);
        checkOutput("wide.v", 32'(bus4.out_valid), 32'h1);

        // Fill the STAGES=3 pipe, then assert reset between edges.
        for (int n = 0; n < 4; n++) begin
            bus3.a = 8'(8'h10 + n); bus3.b = 8'(8'h20 + n); bus3.c = 8'(8'h30 + n);
            bus3.in_valid = 1'b1;
            nextCycle();
        end
        checkAll3("full", 8'h11, 8'h21, 8'h31, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkAll3("async", 8'h00, 8'h00, 8'h00, 1'b0);

        // Edges while reset is held must load nothing.
        bus1.a = 8'hA5; bus1.b = 8'h5A; bus1.c = 8'hFF; bus1.in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            nextCycle();
            checkAll3("hold3", 8'h00, 8'h00, 8'h00, 1'b0);
            checkOutput("hold1.w", 32'(bus1.w), 32'h0);
            checkOutput("hold1.v", 32'(bus1.out_valid), 32'h0);
            checkOutput("hold4.w", 32'(bus4.w), 32'h0);
        end

        // Release, then new data must take 3 cycles to appear.
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            na = 8'(8'h40 + n); nb = 8'(8'h50 + n); nc = 8'(8'h60 + n);
            bus3.a = na; bus3.b = nb; bus3.c = nc; bus3.in_valid = 1'b1;
            nextCycle();
            if (n < 2) begin
                checkAll3("post.zero", 8'h00, 8'h00, 8'h00, 1'b0);
            end else begin
                checkAll3("post.data", 8'(8'h40 + n - 2), 8'(8'h50 + n - 2), 8'(8'h60 + n - 2), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
